// File: rtl/cpu_clock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clock_pkg
// Purpose  : Shared types and constants for the CPU clock-enable controller.
//            clk_state_t is also the encoding driven on state_o.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_clock_pkg;

    // 2'b11 is deliberately left unused; the FSM recovers from it to HALT.
    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } clk_state_t;

    // Depth of every input synchronizer.
    localparam int SYNC_STAGES = 2;

endpackage
`default_nettype wire

// File: rtl/cpu_clock_ctrl_step_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : step_debouncer
// Purpose  : Synchronizes the raw step push-button into clk_in, debounces it
//            and produces a one-cycle pulse on each debounced press.
// Ports    : clk_in    - system clock
//            reset     - asynchronous active-high reset
//            btn_raw   - bouncy, asynchronous button input
//            btn_level - debounced button level
//            btn_rise  - one-cycle pulse on the debounced 0->1 transition
// Revision : 1.0 - initial release
// ============================================================================
module step_debouncer
    import cpu_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise
);

    localparam int c_DB_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_DB_CNT_W-1:0] c_DB_LAST = c_DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_DB_CNT_W-1:0]  r_cnt;
    logic                   r_level;
    logic                   r_level_d;
    logic                   w_btn_s;

    assign w_btn_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], btn_raw};
            r_level_d <= r_level;
            // The counter measures how long the input has disagreed with the
            // debounced level; any agreeing sample restarts the measurement.
            if (w_btn_s == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_DB_LAST) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_DB_CNT_W'(1);
            end
        end
    end

    assign btn_level = r_level;
    assign btn_rise  = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clock_ctrl
// Purpose  : Turns the slow-clock square wave (free-run) or a debounced step
//            button (single-step) into a one-cycle CPU enable in the clk_in
//            domain. The CPU is clocked by clk_in and advances on cpu_en.
// Ports    : clk_in    - system clock, all logic on its rising edge
//            reset     - asynchronous active-high reset
//            slow_clk  - slow-clock divider output (async)
//            step_btn  - raw step push-button (async, bouncy)
//            mode_run  - 1 = free-run, 0 = single-step (async)
//            halt_req  - halt request from the CPU (clk_in synchronous, level)
//            cpu_en    - one-cycle CPU enable
//            state_o   - current FSM state (HALT=00, RUN=01, STEP=10)
//            cycle_cnt - number of cpu_en pulses issued
// Options  : CPU_CYCLE_COUNTER_EN - when defined, cycle_cnt counts cpu_en
//            pulses (wrapping); otherwise cycle_cnt is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_clock_ctrl
    import cpu_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_W           = 32
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic             step_btn,
    input  logic             mode_run,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cycle_cnt
);

    // slow_clk pipe: SYNC_STAGES synchronizer flops plus one history flop
    // used for edge detection.
    logic [SYNC_STAGES:0]   r_slow_pipe;
    logic [SYNC_STAGES-1:0] r_mode_sync;
    clk_state_t             r_state;
    logic                   r_cpu_en;

    logic w_slow_rise;
    logic w_mode_run_s;
    logic w_btn_level;
    logic w_btn_rise;
    logic w_step_req;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_slow_pipe <= '0;
            r_mode_sync <= '0;
        end else begin
            r_slow_pipe <= {r_slow_pipe[SYNC_STAGES-1:0], slow_clk};
            r_mode_sync <= {r_mode_sync[SYNC_STAGES-2:0], mode_run};
        end
    end

    assign w_slow_rise  = r_slow_pipe[SYNC_STAGES-1] & ~r_slow_pipe[SYNC_STAGES];
    assign w_mode_run_s = r_mode_sync[SYNC_STAGES-1];

    step_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_debouncer (
        .clk_in    (clk_in),
        .reset     (reset),
        .btn_raw   (step_btn),
        .btn_level (w_btn_level),
        .btn_rise  (w_btn_rise)
    );

    // A debounced press is only valid while the debounced level is high.
    assign w_step_req = w_btn_rise & w_btn_level;

    // Halt beats mode changes, which beat pulse generation. The pulse decision
    // always uses the state held before this edge, and a pulse is never
    // issued right after another, which matters across a RUN<->STEP switch.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state  <= HALT;
            r_cpu_en <= 1'b0;
        end else begin
            r_cpu_en <= 1'b0;
            case (r_state)
                HALT: begin
                    // The press that leaves HALT is consumed without a pulse.
                    if (w_step_req && !halt_req) begin
                        r_state <= w_mode_run_s ? RUN : STEP;
                    end
                end
                RUN: begin
                    if (halt_req) begin
                        r_state <= HALT;
                    end else begin
                        r_cpu_en <= w_slow_rise & ~r_cpu_en;
                        if (!w_mode_run_s) begin
                            r_state <= STEP;
                        end
                    end
                end
                STEP: begin
                    if (halt_req) begin
                        r_state <= HALT;
                    end else begin
                        r_cpu_en <= w_step_req & ~r_cpu_en;
                        if (w_mode_run_s) begin
                            r_state <= RUN;
                        end
                    end
                end
                default: begin
                    r_state <= HALT;
                end
            endcase
        end
    end

    assign cpu_en  = r_cpu_en;
    assign state_o = r_state;

`ifdef CPU_CYCLE_COUNTER_EN
    logic [CNT_W-1:0] r_cycle_cnt;

    // cpu_en is never high while in HALT, so the count holds there.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_cycle_cnt <= '0;
        end else if (r_cpu_en) begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
        end
    end

    assign cycle_cnt = r_cycle_cnt;
`else
    assign cycle_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_clock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_clock_ctrl
// Purpose  : Self-checking bench for cpu_clock_ctrl (DEBOUNCE_CYCLES=4,
//            CNT_W=8): directed vector table, random stimulus against a
//            cycle-level reference model, counter wrap and async reset.
// Options  : CPU_CYCLE_COUNTER_EN selects the expected cycle_cnt behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_clock_ctrl;

    localparam int c_DB = 4;
    localparam int c_CW = 8;
`ifdef CPU_CYCLE_COUNTER_EN
    localparam bit c_FEAT = 1'b1;
`else
    localparam bit c_FEAT = 1'b0;
`endif

    logic            clk_in   = 1'b0;
    logic            reset    = 1'b1;
    logic            slow_clk = 1'b0;
    logic            step_btn = 1'b0;
    logic            mode_run = 1'b0;
    logic            halt_req = 1'b0;
    logic            cpu_en;
    logic [1:0]      state_o;
    logic [c_CW-1:0] cycle_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int n_pulses = 0;
    bit chk_on   = 1'b0;

    cpu_clock_ctrl #(
        .DEBOUNCE_CYCLES (c_DB),
        .CNT_W           (c_CW)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .slow_clk  (slow_clk),
        .step_btn  (step_btn),
        .mode_run  (mode_run),
        .halt_req  (halt_req),
        .cpu_en    (cpu_en),
        .state_o   (state_o),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk_in = ~clk_in;

    function automatic int exp_cnt(input int v);
        return c_FEAT ? (v % (1 << c_CW)) : 0;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. Input histories (index 0 = sample at this edge) give
    // the synchronized view of each async input two edges late; the button
    // level flips once the last c_DB synchronized samples all disagree with
    // it. States: 0 halt, 1 free-run, 2 single-step.
    // ------------------------------------------------------------------
    bit          sh [0:7];
    bit          bh [0:7];
    bit          mh [0:7];
    bit          m_lvl, m_lvl_d, m_en;
    int          m_state;
    int unsigned m_cnt;

    task automatic model_step();
        bit rise, req, flip, ms, old_en;
        for (int i = 7; i > 0; i--) begin
            sh[i] = sh[i-1];
            bh[i] = bh[i-1];
            mh[i] = mh[i-1];
        end
        sh[0] = slow_clk;
        bh[0] = step_btn;
        mh[0] = mode_run;
        rise  = sh[2] && !sh[3];
        ms    = mh[2];
        req   = m_lvl && !m_lvl_d;
        flip  = 1'b1;
        for (int j = 2; j < 2 + c_DB; j++) begin
            if (bh[j] == m_lvl) flip = 1'b0;
        end
        old_en  = m_en;
        m_cnt   = m_cnt + (old_en ? 1 : 0);
        m_lvl_d = m_lvl;
        if (flip) m_lvl = !m_lvl;
        m_en = 1'b0;
        case (m_state)
            0: if (req && !halt_req) m_state = ms ? 1 : 2;
            1: begin
                if (halt_req) m_state = 0;
                else begin
                    m_en = rise && !old_en;
                    if (!ms) m_state = 2;
                end
            end
            default: begin
                if (halt_req) m_state = 0;
                else begin
                    m_en = req && !old_en;
                    if (ms) m_state = 1;
                end
            end
        endcase
    endtask

    always @(posedge clk_in or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                sh[i] = 1'b0;
                bh[i] = 1'b0;
                mh[i] = 1'b0;
            end
            m_lvl   = 1'b0;
            m_lvl_d = 1'b0;
            m_en    = 1'b0;
            m_state = 0;
            m_cnt   = 0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk_in) begin
        if (cpu_en) n_pulses++;
        if (chk_on) begin
            check("model.cpu_en", cpu_en, m_en);
            check("model.state_o", state_o, m_state);
            check("model.cycle_cnt", cycle_cnt, exp_cnt(m_cnt));
        end
    end

    // ------------------------------------------------------------------
    // Directed vectors: hold inputs for cyc edges, then check outputs.
    // ------------------------------------------------------------------
    typedef struct {
        int cyc;
        bit slow, btn, mode, halt;
        bit en;
        int st;
        int cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int cyc, input bit s, input bit b, input bit m, input bit h,
                       input bit e, input int st, input int cnt);
        vec_t v;
        v.cyc = cyc; v.slow = s; v.btn = b; v.mode = m; v.halt = h;
        v.en = e; v.st = st; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    initial begin
        int p0;
        int slow_left;
        int btn_left;

        // idle after reset, then enter RUN with a press (no pulse)
        add(20, 0, 0, 0, 0, 0, 0, 0);
        add( 6, 0, 1, 1, 0, 0, 0, 0);
        add( 1, 0, 0, 1, 0, 0, 1, 0);
        add(10, 0, 0, 1, 0, 0, 1, 0);
        // three slow_clk rises, each pulsing on the 3rd edge
        for (int k = 0; k < 3; k++) begin
            add( 2, 1, 0, 1, 0, 0, 1, k);
            add( 1, 1, 0, 1, 0, 1, 1, k);
            add( 7, 1, 0, 1, 0, 0, 1, k + 1);
            add(10, 0, 0, 1, 0, 0, 1, k + 1);
        end
        // single-step: bounce, then a real press while slow_clk rises
        add( 3, 0, 0, 0, 0, 0, 2, 3);
        add( 1, 0, 1, 0, 0, 0, 2, 3);
        add( 1, 0, 0, 0, 0, 0, 2, 3);
        add( 1, 0, 1, 0, 0, 0, 2, 3);
        add( 1, 0, 0, 0, 0, 0, 2, 3);
        add( 6, 1, 1, 0, 0, 0, 2, 3);
        add( 1, 1, 0, 0, 0, 1, 2, 3);
        add(12, 0, 0, 0, 0, 0, 2, 4);
        // back to RUN, then halt on the very cycle of the slow rise
        add( 3, 0, 0, 1, 0, 0, 1, 4);
        add( 2, 1, 0, 1, 0, 0, 1, 4);
        add( 1, 1, 0, 1, 1, 0, 0, 4);
        add( 7, 1, 0, 1, 0, 0, 0, 4);
        add(10, 0, 0, 1, 0, 0, 0, 4);
        add(10, 1, 0, 1, 0, 0, 0, 4);
        add(10, 0, 0, 1, 0, 0, 0, 4);

        // reset held 5 cycles
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        check("reset.cpu_en", cpu_en, 0);
        check("reset.state_o", state_o, 0);
        check("reset.cycle_cnt", cycle_cnt, 0);
        reset  = 1'b0;
        chk_on = 1'b1;

        foreach (tbl[i]) begin
            slow_clk = tbl[i].slow;
            step_btn = tbl[i].btn;
            mode_run = tbl[i].mode;
            halt_req = tbl[i].halt;
            repeat (tbl[i].cyc) @(posedge clk_in);
            @(negedge clk_in);
            check($sformatf("tbl%0d.cpu_en", i), cpu_en, tbl[i].en);
            check($sformatf("tbl%0d.state_o", i), state_o, tbl[i].st);
            check($sformatf("tbl%0d.cycle_cnt", i), cycle_cnt, exp_cnt(tbl[i].cnt));
        end

        // random stimulus, checked every cycle by the model
        slow_left = 0;
        btn_left  = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_in);
            if (slow_left == 0) begin
                slow_clk  = !slow_clk;
                slow_left = $urandom_range(12, 3);
            end else begin
                slow_left--;
            end
            if (btn_left == 0) begin
                step_btn = 1'($urandom_range(1, 0));
                btn_left = ($urandom_range(3, 0) == 0) ? $urandom_range(12, 5)
                                                        : $urandom_range(3, 1);
            end else begin
                btn_left--;
            end
            if ($urandom_range(99, 0) == 0) mode_run = !mode_run;
            halt_req = ($urandom_range(59, 0) == 0);
        end

        // counter wrap: clean restart, enter RUN, 256 slow rises
        @(negedge clk_in);
        slow_clk = 1'b0; step_btn = 1'b0; mode_run = 1'b1; halt_req = 1'b0;
        @(posedge clk_in);
        #3 reset = 1'b1;
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        repeat (4) @(negedge clk_in);
        step_btn = 1'b1;
        repeat (6) @(negedge clk_in);
        step_btn = 1'b0;
        repeat (12) @(negedge clk_in);
        check("wrap.enter_run", state_o, 1);
        p0 = n_pulses;
        for (int k = 0; k < 256; k++) begin
            slow_clk = 1'b1;
            repeat (4) @(negedge clk_in);
            slow_clk = 1'b0;
            repeat (4) @(negedge clk_in);
            if (k == 254) check("wrap.cnt255", cycle_cnt, exp_cnt(255));
        end
        repeat (4) @(negedge clk_in);
        check("wrap.pulses", n_pulses - p0, 256);
        check("wrap.cnt0", cycle_cnt, 0);

        // async reset in the middle of a slow_clk high phase
        slow_clk = 1'b1;
        repeat (4) @(negedge clk_in);
        check("areset.pre_state", state_o, 1);
        check("areset.pre_cnt", cycle_cnt, exp_cnt(1));
        @(posedge clk_in);
        #3 reset = 1'b1;
        #1;
        check("areset.cpu_en", cpu_en, 0);
        check("areset.state_o", state_o, 0);
        check("areset.cycle_cnt", cycle_cnt, 0);
        repeat (2) @(negedge clk_in);
        reset = 1'b0;
        repeat (5) @(negedge clk_in);
        check("areset.after_state", state_o, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
